scarv_cop: RTL and testbench
============================

// Module: scarv_cop
//
// PURPOSE
// Reduced SCARV crypto coprocessor (COP) attached to a RISC-V CPU. The CPU hands over one
// encoded instruction plus its RS1 value per request/ack handshake. The COP executes it on a
// private 16x32 register file (c0..c15) and may access memory over a word-aligned
// stall/error bus. It returns an optional GPR write-back and a 3-bit result code.
//
// PARAMETERS
// none (register file fixed at 16x32; c0 reads as zero, writes to c0 are ignored)
//
// PORTS
// g_clk          in   1   clock
// g_resetn       in   1   reset, synchronous, active-low
// g_clk_req      out  1   clock request: 1 when state!=IDLE or cpu_insn_req=1
// cpu_insn_req   in   1   CPU offers instruction
// cop_insn_ack   out  1   COP accepts; transfer when cpu_insn_req&&cop_insn_ack
// cpu_insn_enc   in   32  encoded instruction (sampled on transfer only)
// cpu_rs1        in   32  RS1 value (sampled on transfer only)
// cop_wen        out  1   GPR write enable (valid with cop_insn_rsp)
// cop_waddr      out  5   GPR destination index
// cop_wdata      out  32  GPR write data
// cop_result     out  3   0 ok, 1 bad opcode/funct, 2 misaligned address, 3 bus error
// cop_insn_rsp   out  1   response valid; held until cpu_insn_ack
// cpu_insn_ack   in   1   CPU consumes response
// cop_mem_cen    out  1   memory request
// cop_mem_wen    out  1   1 write, 0 read
// cop_mem_addr   out  32  byte address, bits[1:0]=00
// cop_mem_wdata  out  32  store data
// cop_mem_rdata  in   32  load data, valid in the cycle cen=1 && stall=0
// cop_mem_ben    out  4   byte enables: 4'b1111 for stores, 4'b0000 for loads
// cop_mem_stall  in   1   1 = transaction not complete this cycle
// cop_mem_error  in   1   bus error, sampled with completion
//
// BEHAVIOUR
// - Fields: opc=[6:0] (must be 7'b0101011), f3=[14:12], rd5=[11:7], crd=[10:7],
//   crs1=[18:15], crs2=[23:20], f7=[31:25], imm=sext([31:20]).
// - f3=0 ALU, c[crd]=f(c[crs1],c[crs2]) selected by f7:
//   0 add, 1 sub, 2 and, 3 or, 4 xor, 5 sll, 6 srl, 7 ror. Shift amount = c[crs2][4:0].
//   Arithmetic is mod 2^32. Any other f7 gives result=1.
// - f3=1 MV2COP: c[crd]=rs1.  f3=2 MV2GPR: cop_wen=1, waddr=rd5, wdata=c[crs1].
// - f3=3 LW: c[crd]=rdata, addr=rs1+imm.  f3=4 SW: mem[rs1+imm]=c[crd].
// - f3=5..7, or a wrong opc: result=1, no side effects.
// - FSM IDLE/MEM/RSP. cop_insn_ack=1 only in IDLE and does not depend on cpu_insn_req.
// - IDLE transfer: non-mem ops commit their register write and go to RSP next cycle
//   (1-cycle latency).
// - LW/SW with addr[1:0]!=0: go to RSP with result=2, no bus access.
// - LW/SW aligned: go to MEM. cen=1 with addr/wen/wdata/ben held stable while stalled.
// - MEM completes when stall=0. LW writes c[crd] only if error=0. error=1 gives result=3.
//   Then go to RSP; cen drops in the cycle after completion.
// - RSP: cop_insn_rsp=1 with wen/waddr/wdata/result held. On cpu_insn_ack go to IDLE,
//   so ack=1 the next cycle. There is no back-to-back accept in the same cycle.
// - Outside RSP: cop_wen=0, waddr=0, wdata=0, result=0.
// - Reset (incl. mid-op): state IDLE, all c regs 0, all outputs 0 except cop_insn_ack=1
//   after the first post-reset edge. cen drops immediately and any pending bus transfer
//   is abandoned.
// - Inputs are ignored while not in IDLE. rs1/enc changing after transfer has no effect.
//
// TESTING
// - MV2COP c1<-0x0000_0005, c2<-0xFFFF_FFFF; ALU add c3=c1+c2 -> MV2GPR rd5=7 gives
//   wen=1, waddr=7, wdata=0x0000_0004, result=0.
// - ror c4=c1 rot 1 (c2=1): wdata=0x8000_0002. sub 0-1: wdata=0xFFFF_FFFF.
//   Writes to c0 read back 0.
// - SW c1 to rs1=0x100, imm=4 with stall held 3 cycles: addr=0x104, ben=F,
//   wdata stable for 4 cycles, then rsp result=0.
// - LW with rs1=0x102: result=2, cen never asserted. LW with error=1: result=3,
//   target reg unchanged.
// - f3=6 or opc=0x33: result=1, wen=0, no reg/mem change.
// - Hold cpu_insn_ack=0 for 5 cycles during RSP: outputs stable and cop_insn_ack=0.
//   Reset asserted during MEM: cen=0 and ack=1 after release.

Source files
------------

// File: rtl/scarv_cop.sv
// ---------------------------------------------------------------------------
// scarv_cop : reduced SCARV crypto coprocessor.
//
// Accepts one encoded instruction plus its RS1 value per req/ack handshake,
// executes it on a private 16x32 register file (c0 hard-wired to zero) and
// optionally performs one word access on a stall/error memory bus. Returns a
// GPR write-back and a 3-bit result code, held until the CPU acknowledges.
//
// Ports
//   g_clk, g_resetn                  clock, synchronous active-low reset
//   g_clk_req                        clock request to the clock gate
//   cpu_insn_req / cop_insn_ack      instruction handshake
//   cpu_insn_enc, cpu_rs1            instruction word and RS1 value
//   cop_insn_rsp / cpu_insn_ack      response handshake
//   cop_wen, cop_waddr, cop_wdata    GPR write-back (valid with cop_insn_rsp)
//   cop_result                       0 ok, 1 bad insn, 2 misaligned, 3 bus error
//   cop_mem_*                        word-aligned memory bus
// ---------------------------------------------------------------------------
module scarv_cop (
    input  logic        g_clk,
    input  logic        g_resetn,
    output logic        g_clk_req,
    input  logic        cpu_insn_req,
    output logic        cop_insn_ack,
    input  logic [31:0] cpu_insn_enc,
    input  logic [31:0] cpu_rs1,
    output logic        cop_wen,
    output logic [4:0]  cop_waddr,
    output logic [31:0] cop_wdata,
    output logic [2:0]  cop_result,
    output logic        cop_insn_rsp,
    input  logic        cpu_insn_ack,
    output logic        cop_mem_cen,
    output logic        cop_mem_wen,
    output logic [31:0] cop_mem_addr,
    output logic [31:0] cop_mem_wdata,
    input  logic [31:0] cop_mem_rdata,
    output logic [3:0]  cop_mem_ben,
    input  logic        cop_mem_stall,
    input  logic        cop_mem_error
);

    localparam logic [6:0] OPC_COP      = 7'b0101011;
    localparam logic [2:0] RES_OK       = 3'd0;
    localparam logic [2:0] RES_BAD      = 3'd1;
    localparam logic [2:0] RES_MISALIGN = 3'd2;
    localparam logic [2:0] RES_BUSERR   = 3'd3;

    typedef enum logic [1:0] {S_IDLE, S_MEM, S_RSP} state_t;

    state_t      state_q, state_d;
    logic [31:0] creg_q [16];

    logic        rsp_wen_q,    rsp_wen_d;
    logic [4:0]  rsp_waddr_q,  rsp_waddr_d;
    logic [31:0] rsp_wdata_q,  rsp_wdata_d;
    logic [2:0]  rsp_result_q, rsp_result_d;

    logic        mem_wen_q,   mem_wen_d;
    logic [31:0] mem_addr_q,  mem_addr_d;
    logic [31:0] mem_wdata_q, mem_wdata_d;
    logic [3:0]  mem_crd_q,   mem_crd_d;

    logic        rf_we;
    logic [3:0]  rf_waddr;
    logic [31:0] rf_wdata;

    // Instruction fields (only meaningful in the transfer cycle)
    logic [6:0]  dec_opc, dec_f7;
    logic [2:0]  dec_f3;
    logic [4:0]  dec_rd5;
    logic [3:0]  dec_crd, dec_crs1, dec_crs2;
    logic [31:0] dec_imm, ea, op_a, op_b, alu_res;
    logic [4:0]  shamt;
    logic        alu_ok;
    logic        unused_enc;

    assign dec_opc    = cpu_insn_enc[6:0];
    assign dec_rd5    = cpu_insn_enc[11:7];
    assign dec_crd    = cpu_insn_enc[10:7];
    assign dec_f3     = cpu_insn_enc[14:12];
    assign dec_crs1   = cpu_insn_enc[18:15];
    assign dec_crs2   = cpu_insn_enc[23:20];
    assign dec_f7     = cpu_insn_enc[31:25];
    assign dec_imm    = {{20{cpu_insn_enc[31]}}, cpu_insn_enc[31:20]};
    assign unused_enc = cpu_insn_enc[19];

    assign ea    = cpu_rs1 + dec_imm;
    assign op_a  = creg_q[dec_crs1];
    assign op_b  = creg_q[dec_crs2];
    assign shamt = op_b[4:0];

    always_comb begin
        alu_res = '0;
        alu_ok  = 1'b1;
        case (dec_f7)
            7'd0: alu_res = op_a + op_b;
            7'd1: alu_res = op_a - op_b;
            7'd2: alu_res = op_a & op_b;
            7'd3: alu_res = op_a | op_b;
            7'd4: alu_res = op_a ^ op_b;
            7'd5: alu_res = op_a << shamt;
            7'd6: alu_res = op_a >> shamt;
            // a shift by 32 yields zero, so shamt=0 degenerates to op_a
            7'd7: alu_res = (op_a >> shamt) | (op_a << (6'd32 - {1'b0, shamt}));
            default: alu_ok = 1'b0;
        endcase
    end

    always_comb begin
        state_d      = state_q;
        rsp_wen_d    = rsp_wen_q;
        rsp_waddr_d  = rsp_waddr_q;
        rsp_wdata_d  = rsp_wdata_q;
        rsp_result_d = rsp_result_q;
        mem_wen_d    = mem_wen_q;
        mem_addr_d   = mem_addr_q;
        mem_wdata_d  = mem_wdata_q;
        mem_crd_d    = mem_crd_q;
        rf_we        = 1'b0;
        rf_waddr     = dec_crd;
        rf_wdata     = '0;
        case (state_q)
            S_IDLE: begin
                if (cpu_insn_req) begin
                    state_d      = S_RSP;
                    rsp_wen_d    = 1'b0;
                    rsp_waddr_d  = '0;
                    rsp_wdata_d  = '0;
                    rsp_result_d = RES_OK;
                    if (dec_opc != OPC_COP) begin
                        rsp_result_d = RES_BAD;
                    end else begin
                        case (dec_f3)
                            3'd0: begin
                                if (alu_ok) begin
                                    rf_we    = 1'b1;
                                    rf_wdata = alu_res;
                                end else begin
                                    rsp_result_d = RES_BAD;
                                end
                            end
                            3'd1: begin
                                rf_we    = 1'b1;
                                rf_wdata = cpu_rs1;
                            end
                            3'd2: begin
                                rsp_wen_d   = 1'b1;
                                rsp_waddr_d = dec_rd5;
                                rsp_wdata_d = op_a;
                            end
                            3'd3, 3'd4: begin
                                if (ea[1:0] != 2'b00) begin
                                    rsp_result_d = RES_MISALIGN;
                                end else begin
                                    state_d     = S_MEM;
                                    mem_wen_d   = (dec_f3 == 3'd4);
                                    mem_addr_d  = ea;
                                    mem_wdata_d = creg_q[dec_crd];
                                    mem_crd_d   = dec_crd;
                                end
                            end
                            default: rsp_result_d = RES_BAD;
                        endcase
                    end
                end
            end
            S_MEM: begin
                if (!cop_mem_stall) begin
                    state_d = S_RSP;
                    if (cop_mem_error) begin
                        rsp_result_d = RES_BUSERR;
                    end else if (!mem_wen_q) begin
                        rf_we    = 1'b1;
                        rf_waddr = mem_crd_q;
                        rf_wdata = cop_mem_rdata;
                    end
                end
            end
            S_RSP: begin
                if (cpu_insn_ack) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge g_clk) begin
        if (!g_resetn) begin
            state_q      <= S_IDLE;
            rsp_wen_q    <= 1'b0;
            rsp_waddr_q  <= '0;
            rsp_wdata_q  <= '0;
            rsp_result_q <= '0;
            mem_wen_q    <= 1'b0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
            mem_crd_q    <= '0;
            for (int i = 0; i < 16; i++) creg_q[i] <= '0;
        end else begin
            state_q      <= state_d;
            rsp_wen_q    <= rsp_wen_d;
            rsp_waddr_q  <= rsp_waddr_d;
            rsp_wdata_q  <= rsp_wdata_d;
            rsp_result_q <= rsp_result_d;
            mem_wen_q    <= mem_wen_d;
            mem_addr_q   <= mem_addr_d;
            mem_wdata_q  <= mem_wdata_d;
            mem_crd_q    <= mem_crd_d;
            // c0 is never written so it always reads as zero
            if (rf_we && rf_waddr != 4'd0) creg_q[rf_waddr] <= rf_wdata;
        end
    end

    assign g_clk_req    = (state_q != S_IDLE) || cpu_insn_req;
    assign cop_insn_ack = (state_q == S_IDLE);
    assign cop_insn_rsp = (state_q == S_RSP);
    assign cop_wen      = cop_insn_rsp & rsp_wen_q;
    assign cop_waddr    = cop_insn_rsp ? rsp_waddr_q  : 5'd0;
    assign cop_wdata    = cop_insn_rsp ? rsp_wdata_q  : 32'd0;
    assign cop_result   = cop_insn_rsp ? rsp_result_q : 3'd0;

    assign cop_mem_cen   = (state_q == S_MEM);
    assign cop_mem_wen   = cop_mem_cen & mem_wen_q;
    assign cop_mem_addr  = cop_mem_cen ? mem_addr_q : 32'd0;
    assign cop_mem_wdata = cop_mem_wen ? mem_wdata_q : 32'd0;
    assign cop_mem_ben   = cop_mem_wen ? 4'hF : 4'h0;

endmodule

// File: tb/tb_scarv_cop.sv
module tb_scarv_cop;

    logic        g_clk = 1'b0;
    logic        g_resetn = 1'b0;
    logic        g_clk_req;
    logic        cpu_insn_req = 1'b0;
    logic        cop_insn_ack;
    logic [31:0] cpu_insn_enc = '0;
    logic [31:0] cpu_rs1 = '0;
    logic        cop_wen;
    logic [4:0]  cop_waddr;
    logic [31:0] cop_wdata;
    logic [2:0]  cop_result;
    logic        cop_insn_rsp;
    logic        cpu_insn_ack = 1'b0;
    logic        cop_mem_cen;
    logic        cop_mem_wen;
    logic [31:0] cop_mem_addr;
    logic [31:0] cop_mem_wdata;
    logic [31:0] cop_mem_rdata = '0;
    logic [3:0]  cop_mem_ben;
    logic        cop_mem_stall = 1'b0;
    logic        cop_mem_error = 1'b0;

    scarv_cop dut (
        .g_clk(g_clk), .g_resetn(g_resetn), .g_clk_req(g_clk_req),
        .cpu_insn_req(cpu_insn_req), .cop_insn_ack(cop_insn_ack),
        .cpu_insn_enc(cpu_insn_enc), .cpu_rs1(cpu_rs1),
        .cop_wen(cop_wen), .cop_waddr(cop_waddr), .cop_wdata(cop_wdata),
        .cop_result(cop_result), .cop_insn_rsp(cop_insn_rsp),
        .cpu_insn_ack(cpu_insn_ack),
        .cop_mem_cen(cop_mem_cen), .cop_mem_wen(cop_mem_wen),
        .cop_mem_addr(cop_mem_addr), .cop_mem_wdata(cop_mem_wdata),
        .cop_mem_rdata(cop_mem_rdata), .cop_mem_ben(cop_mem_ben),
        .cop_mem_stall(cop_mem_stall), .cop_mem_error(cop_mem_error)
    );

    always #5 g_clk = ~g_clk;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference state: coprocessor registers and the expected outcome
    logic [31:0] mc [16];
    logic        exp_wen;
    logic [4:0]  exp_waddr;
    logic [31:0] exp_wdata;
    logic [2:0]  exp_result;
    bit          exp_mem;
    bit          exp_mwen;
    logic [31:0] exp_maddr;
    logic [31:0] exp_mwdata;
    bit          chk_en = 1'b0;
    logic [31:0] last_wdata;
    logic [2:0]  last_result;
    int          last_cen_cnt;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", name, act, req);
        end
    endtask

    function automatic logic [31:0] e_r(input logic [6:0] f7, input logic [3:0] s2,
                                        input logic [3:0] s1, input logic [2:0] f3,
                                        input logic [4:0] rd);
        return {f7, 1'b0, s2, 1'b0, s1, f3, rd, 7'h2B};
    endfunction

    function automatic logic [31:0] e_m(input logic [11:0] imm, input logic [2:0] f3,
                                        input logic [3:0] crd);
        return {imm, 5'd0, f3, 1'b0, crd, 7'h2B};
    endfunction

    // Architectural effect of one instruction, straight from the ISA rules
    task automatic model(input logic [31:0] e, input logic [31:0] r1,
                         input logic [31:0] rdata, input bit err);
        logic [31:0] a, b, v, addr;
        int sh, crd;
        bit wr;
        a = mc[e[18:15]];
        b = mc[e[23:20]];
        sh = int'(b[4:0]);
        crd = int'(e[10:7]);
        wr = 0; v = '0;
        exp_wen = 0; exp_waddr = 0; exp_wdata = 0; exp_result = 0;
        exp_mem = 0; exp_mwen = 0; exp_maddr = 0; exp_mwdata = 0;
        if (e[6:0] != 7'h2B) exp_result = 1;
        else case (e[14:12])
            3'd0: begin
                wr = 1;
                case (e[31:25])
                    7'd0: v = a + b;
                    7'd1: v = a - b;
                    7'd2: v = a & b;
                    7'd3: v = a | b;
                    7'd4: v = a ^ b;
                    7'd5: v = a << sh;
                    7'd6: v = a >> sh;
                    7'd7: v = 32'((({a, a} >> sh)) & 64'hFFFF_FFFF);
                    default: begin wr = 0; exp_result = 1; end
                endcase
            end
            3'd1: begin wr = 1; v = r1; end
            3'd2: begin exp_wen = 1; exp_waddr = e[11:7]; exp_wdata = a; end
            3'd3, 3'd4: begin
                addr = r1 + {{20{e[31]}}, e[31:20]};
                if (addr % 4 != 0) exp_result = 2;
                else begin
                    exp_mem = 1; exp_maddr = addr; exp_mwen = (e[14:12] == 3'd4);
                    exp_mwdata = exp_mwen ? mc[crd] : 32'd0;
                    if (err) exp_result = 3;
                    else if (!exp_mwen) begin wr = 1; v = rdata; end
                end
            end
            default: exp_result = 1;
        endcase
        if (wr && crd != 0) mc[crd] = v;
    endtask

    // Response fields checked every cycle against the reference
    always @(negedge g_clk) begin
        if (chk_en) begin
            if (cop_insn_rsp)
                chk("rsp_fields", {cop_wen, 21'd0, cop_waddr, cop_result, 2'b0},
                    {exp_wen, 21'd0, exp_waddr, exp_result, 2'b0});
            if (cop_insn_rsp) chk("rsp_wdata", cop_wdata, exp_wdata);
            else chk("idle_rsp_zero", {cop_wen, cop_waddr, cop_result}, 9'd0);
        end
    end

    task automatic issue(input logic [31:0] enc, input logic [31:0] rs1, input int stall_n,
                         input bit err, input logic [31:0] rdata, input int hold);
        int cnt, k;
        model(enc, rs1, rdata, err);
        @(posedge g_clk); #1;
        cpu_insn_req = 1; cpu_insn_enc = enc; cpu_rs1 = rs1;
        cop_mem_stall = (stall_n > 0); cop_mem_error = err; cop_mem_rdata = rdata;
        @(negedge g_clk);
        chk("ack_idle", {31'd0, cop_insn_ack & g_clk_req}, 32'd1);
        @(posedge g_clk); #1;
        cpu_insn_req = 0; cpu_insn_enc = $urandom; cpu_rs1 = $urandom;
        cnt = 0;
        for (k = 0; k < 40; k++) begin
            @(negedge g_clk);
            if (cop_insn_rsp) break;
            if (cop_mem_cen) begin
                cnt++;
                chk("mem_addr", cop_mem_addr, exp_maddr);
                chk("mem_wdata", cop_mem_wdata, exp_mwdata);
                chk("mem_ctl", {cop_mem_wen, cop_mem_ben}, exp_mwen ? 5'h1F : 5'h00);
                cop_mem_stall = (cnt <= stall_n);
            end
        end
        chk("rsp_seen", {31'd0, cop_insn_rsp}, 32'd1);
        chk("cen_cycles", cnt, exp_mem ? stall_n + 1 : 0);
        last_wdata = cop_wdata; last_result = cop_result; last_cen_cnt = cnt;
        repeat (hold) begin
            @(negedge g_clk);
            chk("hold_state", {30'd0, cop_insn_rsp, cop_insn_ack}, 32'd2);
        end
        @(posedge g_clk); #1 cpu_insn_ack = 1;
        @(posedge g_clk); #1 cpu_insn_ack = 0; cop_mem_stall = 0; cop_mem_error = 0;
        @(negedge g_clk);
        chk("back_idle", {30'd0, cop_insn_rsp, cop_insn_ack}, 32'd1);
    endtask

    initial begin
        for (int i = 0; i < 16; i++) mc[i] = '0;
        repeat (2) @(posedge g_clk);
        @(negedge g_clk);
        chk("reset_outs", {cop_insn_ack, cop_insn_rsp, cop_mem_cen, cop_wen, g_clk_req,
                           cop_result}, 8'b1000_0000);
        chk("reset_bus", cop_mem_addr | cop_mem_wdata | {28'd0, cop_mem_ben}, 32'd0);
        g_resetn = 1; chk_en = 1;

        issue(e_r(0, 0, 0, 1, 1), 32'h5, 0, 0, 0, 0);
        issue(e_r(0, 0, 0, 1, 2), 32'hFFFF_FFFF, 0, 0, 0, 0);
        issue(e_r(0, 2, 1, 0, 3), 0, 0, 0, 0, 0);
        issue(e_r(0, 0, 3, 2, 7), 0, 0, 0, 0, 0);
        chk("lit_add", last_wdata, 32'h0000_0004);

        issue(e_r(0, 0, 0, 1, 2), 32'h1, 0, 0, 0, 0);
        issue(e_r(7, 2, 1, 0, 4), 0, 0, 0, 0, 0);
        issue(e_r(0, 0, 4, 2, 9), 0, 0, 0, 0, 0);
        chk("lit_ror", last_wdata, 32'h8000_0002);
        issue(e_r(1, 2, 0, 0, 5), 0, 0, 0, 0, 0);
        issue(e_r(0, 0, 5, 2, 1), 0, 0, 0, 0, 0);
        chk("lit_sub", last_wdata, 32'hFFFF_FFFF);
        issue(e_r(0, 0, 0, 1, 0), 32'h1234, 0, 0, 0, 0);
        issue(e_r(0, 0, 0, 2, 3), 0, 0, 0, 0, 0);
        chk("lit_c0", last_wdata, 32'h0);

        // remaining ALU ops, each read back through MV2GPR
        for (int f = 2; f < 7; f++) begin
            issue(e_r(7'(f), 1, 4, 0, 4'(8 + f)), 0, 0, 0, 0, 0);
            issue(e_r(0, 0, 4'(8 + f), 2, 5'(20 + f)), 0, 0, 0, 0, 0);
        end

        issue(e_m(12'd4, 3'd4, 4'd1), 32'h100, 3, 0, 0, 0);
        chk("lit_sw_res", {29'd0, last_result}, 32'd0);
        chk("lit_sw_cen", last_cen_cnt, 4);
        issue(e_m(12'd0, 3'd3, 4'd6), 32'h102, 0, 0, 0, 0);
        chk("lit_misalign", {29'd0, last_result}, 32'd2);
        issue(e_m(12'hFFC, 3'd3, 4'd6), 32'h204, 1, 0, 32'hCAFE_BABE, 0);
        issue(e_m(12'd0, 3'd3, 4'd6), 32'h300, 2, 1, 32'h1111_1111, 0);
        chk("lit_buserr", {29'd0, last_result}, 32'd3);
        issue(e_r(0, 0, 6, 2, 6), 0, 0, 0, 0, 0);
        chk("lit_lw_keep", last_wdata, 32'hCAFE_BABE);

        issue(e_r(0, 0, 0, 6, 6) ^ 32'h0, 32'h77, 0, 0, 0, 0);
        chk("lit_f3_6", {29'd0, last_result}, 32'd1);
        issue({e_r(0, 0, 0, 1, 6)} & 32'hFFFF_FF80 | 32'h33, 32'h77, 0, 0, 0, 0);
        chk("lit_opc", {29'd0, last_result}, 32'd1);
        issue(e_r(9, 1, 1, 0, 6), 0, 0, 0, 0, 0);
        issue(e_r(0, 0, 6, 2, 6), 0, 0, 0, 0, 5);
        chk("lit_after_bad", last_wdata, 32'hCAFE_BABE);

        // reset while a stalled store is on the bus
        @(posedge g_clk); #1;
        cpu_insn_req = 1; cpu_insn_enc = e_m(12'd0, 3'd4, 4'd1); cpu_rs1 = 32'h100;
        cop_mem_stall = 1;
        @(posedge g_clk); #1 cpu_insn_req = 0;
        repeat (2) @(negedge g_clk);
        chk("mem_before_rst", {31'd0, cop_mem_cen}, 32'd1);
        chk_en = 0;
        @(posedge g_clk); #1 g_resetn = 0;
        @(posedge g_clk); #1;
        chk("rst_mid_mem", {29'd0, cop_mem_cen, cop_insn_ack, cop_insn_rsp}, 32'b010);
        g_resetn = 1; cop_mem_stall = 0;
        for (int i = 0; i < 16; i++) mc[i] = '0;
        chk_en = 1;
        issue(e_r(0, 0, 1, 2, 3), 0, 0, 0, 0, 0);
        chk("lit_rst_clr", last_wdata, 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
